// File: rtl/gate_pkg.sv
// gate_bank_pipe shared definitions.
// Gate slot indices in the packed result bus and FSM state encoding.
package gate_pkg;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 3;
  localparam int GATE_XOR  = 4;
  localparam int GATE_XNOR = 5;
  localparam int GATE_NUM  = 6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/gate_bank_pipe_slice.sv
// gate_slice: combinational six-function evaluator.
// Result bus is {xnor,xor,nor,nand,or,and}, WIDTH bits per slot.
module gate_slice
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]          a_i,
  input  logic [WIDTH-1:0]          b_i,
  output logic [GATE_NUM*WIDTH-1:0] ot_o
);

  // evaluate all six gates in parallel
  always_comb begin
    ot_o = '0;
    ot_o[GATE_AND*WIDTH  +: WIDTH] = a_i & b_i;
    ot_o[GATE_OR*WIDTH   +: WIDTH] = a_i | b_i;
    ot_o[GATE_NAND*WIDTH +: WIDTH] = ~(a_i & b_i);
    ot_o[GATE_NOR*WIDTH  +: WIDTH] = ~(a_i | b_i);
    ot_o[GATE_XOR*WIDTH  +: WIDTH] = a_i ^ b_i;
    ot_o[GATE_XNOR*WIDTH +: WIDTH] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gate_bank_pipe.sv
// gate_bank_pipe: pipelined six-gate bank with packet accumulate mode.
// Optional GATE_STATS_EN adds saturating beat_cnt / pkt_cnt outputs.
module gate_bank_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          a,
  input  logic [WIDTH-1:0]          b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [GATE_NUM*WIDTH-1:0] ot,
`ifdef GATE_STATS_EN
  output logic [CNT_W-1:0]          beat_cnt,
  output logic [CNT_W-1:0]          pkt_cnt,
`endif
  output logic                      out_last
);

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          acc_and_q, acc_or_q, acc_xor_q;
  logic [WIDTH-1:0]          fold_and, fold_or, fold_xor;
  logic                      out_valid_q, out_last_q;
  logic [GATE_NUM*WIDTH-1:0] ot_q;
  logic [GATE_NUM*WIDTH-1:0] beat_ot, acc_ot, res_ot;
  logic                      accept, emit, start_pkt;

  gate_slice #(.WIDTH(WIDTH)) u_slice (
    .a_i  (a),
    .b_i  (b),
    .ot_o (beat_ot)
  );

  // non-last packet beats bypass the output stage
  always_comb begin
    in_ready = !out_valid_q || out_ready
            || (state_q == ST_ACC && !in_last);
    accept   = in_valid && in_ready;
  end

  // accumulator fold including the current beat
  always_comb begin
    fold_and = acc_and_q & a & b;
    fold_or  = acc_or_q | a | b;
    fold_xor = acc_xor_q ^ a ^ b;
    acc_ot   = '0;
    acc_ot[GATE_AND*WIDTH  +: WIDTH] = fold_and;
    acc_ot[GATE_OR*WIDTH   +: WIDTH] = fold_or;
    acc_ot[GATE_NAND*WIDTH +: WIDTH] = ~fold_and;
    acc_ot[GATE_NOR*WIDTH  +: WIDTH] = ~fold_or;
    acc_ot[GATE_XOR*WIDTH  +: WIDTH] = fold_xor;
    acc_ot[GATE_XNOR*WIDTH +: WIDTH] = ~fold_xor;
    res_ot   = (state_q == ST_ACC) ? acc_ot : beat_ot;
  end

  // packet FSM next state and emit decision
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    start_pkt = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode && !in_last) begin
            state_d   = ST_ACC;
            start_pkt = 1'b1;
          end else begin
            emit = 1'b1;
          end
        end
        ST_ACC: begin
          if (in_last) begin
            state_d = ST_IDLE;
            emit    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // accumulators: first beat loads, later beats fold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_and_q <= '0;
      acc_or_q  <= '0;
      acc_xor_q <= '0;
    end else if (start_pkt) begin
      acc_and_q <= a & b;
      acc_or_q  <= a | b;
      acc_xor_q <= a ^ b;
    end else if (accept && state_q == ST_ACC) begin
      acc_and_q <= fold_and;
      acc_or_q  <= fold_or;
      acc_xor_q <= fold_xor;
    end
  end

  // single output register, reloadable while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ot_q        <= '0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b1;
      ot_q        <= res_ot;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign ot        = ot_q;

`ifdef GATE_STATS_EN
  logic [CNT_W-1:0] beat_cnt_q, pkt_cnt_q;

  // saturating beat / result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (accept && beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 1'b1;
      if (emit && pkt_cnt_q != '1)    pkt_cnt_q  <= pkt_cnt_q + 1'b1;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign pkt_cnt  = pkt_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_gate_bank_pipe.sv
// tb_gate_bank_pipe: directed + random checks against a behavioural model.
// Define GATE_STATS_EN to also check the saturating counters.
module tb_gate_bank_pipe;

  localparam int W  = 8;
  localparam int CW = 4;
  localparam int OW = 6 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_last;
  logic [OW-1:0] ot;
`ifdef GATE_STATS_EN
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] pkt_cnt;
`endif

  always #5 clk = ~clk;

  gate_bank_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ot        (ot),
`ifdef GATE_STATS_EN
    .beat_cnt  (beat_cnt),
    .pkt_cnt   (pkt_cnt),
`endif
    .out_last  (out_last)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // reference model state
  bit            m_ov, m_ol, m_pkt;
  logic [OW-1:0] m_ot;
  logic [W-1:0]  m_and, m_or, m_xor;
  int            m_beats, m_pkts;

  function automatic logic [OW-1:0] pack3(logic [W-1:0] x_and,
                                          logic [W-1:0] x_or,
                                          logic [W-1:0] x_xor);
    return {~x_xor, x_xor, ~x_or, ~x_and, x_or, x_and};
  endfunction

  task automatic model_reset();
    m_ov = 0; m_ol = 0; m_pkt = 0; m_ot = '0;
    m_and = '0; m_or = '0; m_xor = '0;
    m_beats = 0; m_pkts = 0;
  endtask

  function automatic int sat_inc(int v);
    return (v < (1 << CW) - 1) ? v + 1 : v;
  endfunction

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("ot", 64'(ot), 64'(m_ot));
    check("out_last", 64'(out_last), 64'(m_ol));
`ifdef GATE_STATS_EN
    check("beat_cnt", 64'(beat_cnt), 64'(m_beats));
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkts));
`endif
  endtask

  // drive one cycle from a negedge, predict, end at next negedge
  task automatic cycle(bit v, bit l, bit md,
                       logic [W-1:0] va, logic [W-1:0] vb, bit rdy);
    bit            exp_rdy, acc, emit;
    logic [OW-1:0] res;
    in_valid = v; in_last = l; mode = md;
    a = va; b = vb; out_ready = rdy;
    #1;
    exp_rdy = !m_ov || rdy || (m_pkt && !l);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc  = v && exp_rdy;
    emit = 0;
    res  = '0;
    if (acc) begin
      m_beats = sat_inc(m_beats);
      if (!m_pkt) begin
        if (md && !l) begin
          m_pkt = 1;
          m_and = va & vb; m_or = va | vb; m_xor = va ^ vb;
        end else begin
          emit = 1;
          res  = pack3(va & vb, va | vb, va ^ vb);
        end
      end else begin
        m_and = m_and & va & vb;
        m_or  = m_or | va | vb;
        m_xor = m_xor ^ va ^ vb;
        if (l) begin
          emit  = 1;
          res   = pack3(m_and, m_or, m_xor);
          m_pkt = 0;
        end
      end
    end
    if (emit) begin
      m_ov = 1; m_ol = 1; m_ot = res;
      m_pkts = sat_inc(m_pkts);
    end else if (rdy) begin
      m_ov = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  logic [W-1:0] ra, rb;

  initial begin
    model_reset();
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_ot", 64'(ot), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle(0, 0, 0, '0, '0, 1);

    cycle(1, 0, 0, 8'h0F, 8'h33, 1);
    check("t2_ot", 64'(ot), 64'h0000_C33C_C0FC_3F03);
    check("t2_valid", 64'(out_valid), 64'd1);

    cycle(0, 0, 0, '0, '0, 1);
    cycle(1, 0, 0, 8'h12, 8'h34, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, W'($urandom), W'($urandom), 0);
      check("t3_hold_ot", 64'(ot), 64'(pack3(8'h10, 8'h36, 8'h26)));
    end
    cycle(1, 0, 0, 8'hC5, 8'h5A, 1);
    check("t3_reload", 64'(ot), 64'(pack3(8'h40, 8'hDF, 8'h9F)));
    check("t3_no_bubble", 64'(out_valid), 64'd1);
    cycle(0, 0, 0, '0, '0, 1);

    cycle(1, 0, 1, 8'hF0, 8'hFF, 1);
    cycle(1, 0, 1, 8'h3C, 8'h0F, 1);
    check("t4_no_early", 64'(out_valid), 64'd0);
    cycle(1, 1, 0, 8'hFF, 8'h81, 1);
    check("t4_ot", 64'(ot), 64'h0000_BD42_00FF_FF00);
    check("t4_valid", 64'(out_valid), 64'd1);
    cycle(0, 0, 0, '0, '0, 1);

    cycle(1, 0, 1, 8'h11, 8'h22, 1);
    cycle(1, 0, 1, 8'h33, 8'h44, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, '0, '0, 1);
    cycle(1, 0, 0, 8'hAA, 8'h55, 1);
    check("t5_ot", 64'(ot), 64'h0000_00FF_00FF_FF00);

    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)), ra, rb,
            $urandom_range(0, 3) != 0);
    end

`ifdef GATE_STATS_EN
    cycle(0, 0, 0, '0, '0, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      cycle(1, 0, 0, ra, rb, 1);
    end
    check("t6_beat_sat", 64'(beat_cnt), 64'hF);
    check("t6_pkt_sat", 64'(pkt_cnt), 64'hF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
